// File: rtl/axi_pkg.sv
// Shared AXI constants and helpers for the AXI RAM front ends.
// Burst encodings, response codes, FSM state type and size clamp.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED      = 2'b00,
    INCR       = 2'b01,
    WRAP       = 2'b10,
    BURST_RSVD = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    IDLE,
    BURST
  } rd_state_t;

  function automatic logic [2:0] clamp_size(
    input logic [2:0] size,
    input logic [2:0] max_size
  );
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi_ram_rd_if_if.sv
// AR/R slave port plus RAM read command/response port.
// slave = the read front end, master = the surrounding system.
interface axi_ram_rd_if_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 8,
  parameter int ARUSER_WIDTH = 1,
  parameter int RUSER_WIDTH  = 1
);
  logic [ID_WIDTH-1:0]     s_axi_arid;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]              s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  logic                    s_axi_arlock;
  logic [3:0]              s_axi_arcache;
  logic [2:0]              s_axi_arprot;
  logic [3:0]              s_axi_arqos;
  logic [3:0]              s_axi_arregion;
  logic [ARUSER_WIDTH-1:0] s_axi_aruser;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;

  logic [ID_WIDTH-1:0]     s_axi_rid;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;
  logic [RUSER_WIDTH-1:0]  s_axi_ruser;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  logic [ID_WIDTH-1:0]     ram_rd_cmd_id;
  logic [ADDR_WIDTH-1:0]   ram_rd_cmd_addr;
  logic                    ram_rd_cmd_lock;
  logic [3:0]              ram_rd_cmd_cache;
  logic [2:0]              ram_rd_cmd_prot;
  logic [3:0]              ram_rd_cmd_qos;
  logic [3:0]              ram_rd_cmd_region;
  logic [ARUSER_WIDTH-1:0] ram_rd_cmd_auser;
  logic                    ram_rd_cmd_en;
  logic                    ram_rd_cmd_last;
  logic                    ram_rd_cmd_ready;

  logic [ID_WIDTH-1:0]     ram_rd_resp_id;
  logic [DATA_WIDTH-1:0]   ram_rd_resp_data;
  logic                    ram_rd_resp_last;
  logic [RUSER_WIDTH-1:0]  ram_rd_resp_user;
  logic                    ram_rd_resp_valid;
  logic                    ram_rd_resp_ready;

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
    input  s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot,
    input  s_axi_arqos, s_axi_arregion, s_axi_aruser, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
    output s_axi_ruser, s_axi_rvalid,
    input  s_axi_rready,
    output ram_rd_cmd_id, ram_rd_cmd_addr, ram_rd_cmd_lock,
    output ram_rd_cmd_cache, ram_rd_cmd_prot, ram_rd_cmd_qos,
    output ram_rd_cmd_region, ram_rd_cmd_auser, ram_rd_cmd_en,
    output ram_rd_cmd_last,
    input  ram_rd_cmd_ready,
    input  ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
    input  ram_rd_resp_user, ram_rd_resp_valid,
    output ram_rd_resp_ready
  );

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
    output s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot,
    output s_axi_arqos, s_axi_arregion, s_axi_aruser, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
    input  s_axi_ruser, s_axi_rvalid,
    output s_axi_rready,
    input  ram_rd_cmd_id, ram_rd_cmd_addr, ram_rd_cmd_lock,
    input  ram_rd_cmd_cache, ram_rd_cmd_prot, ram_rd_cmd_qos,
    input  ram_rd_cmd_region, ram_rd_cmd_auser, ram_rd_cmd_en,
    input  ram_rd_cmd_last,
    output ram_rd_cmd_ready,
    output ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
    output ram_rd_resp_user, ram_rd_resp_valid,
    input  ram_rd_resp_ready
  );

endinterface

// File: rtl/axi_ram_rd_skid.sv
// Two-entry registered skid buffer for the R channel.
// Used by axi_ram_rd_if when AXI_RAM_RD_IF_PIPELINE_OUTPUT_EN is set.
module axi_ram_rd_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // Ready only depends on state, so the RAM side sees no comb path.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid  <= skid_valid || in_valid;
      skid_valid <= 1'b0;
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!out_valid || out_ready) begin
      out_data <= skid_valid ? skid_data : in_data;
    end else if (in_valid && !skid_valid) begin
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/axi_ram_rd_if.sv
// AXI4 read front end: AR burst -> per-beat RAM commands, RAM resp -> R.
// Define AXI_RAM_RD_IF_PIPELINE_OUTPUT_EN to register R via a skid buffer.
module axi_ram_rd_if
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int ARUSER_ENABLE = 0,
  parameter int ARUSER_WIDTH  = 1,
  parameter int RUSER_ENABLE  = 0,
  parameter int RUSER_WIDTH   = 1
) (
  input logic            clk,
  input logic            rst,
  axi_ram_rd_if_if.slave bus
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));
  localparam int R_W = ID_WIDTH + DATA_WIDTH + 1 + RUSER_WIDTH;

  rd_state_t state, state_next;
  logic arready, arready_next;
  logic cmd_en, cmd_en_next;
  logic cmd_last, cmd_last_next;
  logic [ID_WIDTH-1:0] id, id_next;
  logic [ADDR_WIDTH-1:0] addr, addr_next;
  logic lock, lock_next;
  logic [3:0] cache, cache_next;
  logic [2:0] prot, prot_next;
  logic [3:0] qos, qos_next;
  logic [3:0] region, region_next;
  logic [ARUSER_WIDTH-1:0] auser, auser_next;
  logic [7:0] count, count_next;
  burst_t burst, burst_next;
  logic [2:0] size, size_next;

  always_comb begin
    state_next    = state;
    arready_next  = arready;
    cmd_en_next   = cmd_en;
    cmd_last_next = cmd_last;
    id_next       = id;
    addr_next     = addr;
    lock_next     = lock;
    cache_next    = cache;
    prot_next     = prot;
    qos_next      = qos;
    region_next   = region;
    auser_next    = auser;
    count_next    = count;
    burst_next    = burst;
    size_next     = size;
    unique case (state)
      IDLE: begin
        arready_next = 1'b1;
        if (bus.s_axi_arvalid && arready) begin
          id_next       = bus.s_axi_arid;
          addr_next     = bus.s_axi_araddr;
          lock_next     = bus.s_axi_arlock;
          cache_next    = bus.s_axi_arcache;
          prot_next     = bus.s_axi_arprot;
          qos_next      = bus.s_axi_arqos;
          region_next   = bus.s_axi_arregion;
          auser_next    = bus.s_axi_aruser;
          count_next    = bus.s_axi_arlen;
          burst_next    = burst_t'(bus.s_axi_arburst);
          size_next     = clamp_size(bus.s_axi_arsize, MAX_SIZE);
          cmd_last_next = (bus.s_axi_arlen == 8'd0);
          cmd_en_next   = 1'b1;
          arready_next  = 1'b0;
          state_next    = BURST;
        end
      end
      BURST: begin
        if (cmd_en && bus.ram_rd_cmd_ready) begin
          // WRAP steps like INCR; address rolls over at the top.
          if (burst != FIXED) begin
            addr_next = addr + (ADDR_WIDTH'(1) << size);
          end
          count_next    = count - 8'd1;
          cmd_last_next = (count_next == 8'd0);
          if (count == 8'd0) begin
            cmd_en_next  = 1'b0;
            arready_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      arready <= 1'b0;
      cmd_en  <= 1'b0;
    end else begin
      state   <= state_next;
      arready <= arready_next;
      cmd_en  <= cmd_en_next;
    end
  end

  always_ff @(posedge clk) begin
    cmd_last <= cmd_last_next;
    id       <= id_next;
    addr     <= addr_next;
    lock     <= lock_next;
    cache    <= cache_next;
    prot     <= prot_next;
    qos      <= qos_next;
    region   <= region_next;
    auser    <= auser_next;
    count    <= count_next;
    burst    <= burst_next;
    size     <= size_next;
  end

  assign bus.s_axi_arready     = arready;
  assign bus.ram_rd_cmd_en     = cmd_en;
  assign bus.ram_rd_cmd_last   = cmd_last;
  assign bus.ram_rd_cmd_id     = id;
  assign bus.ram_rd_cmd_addr   = addr;
  assign bus.ram_rd_cmd_lock   = lock;
  assign bus.ram_rd_cmd_cache  = cache;
  assign bus.ram_rd_cmd_prot   = prot;
  assign bus.ram_rd_cmd_qos    = qos;
  assign bus.ram_rd_cmd_region = region;
  assign bus.ram_rd_cmd_auser  = (ARUSER_ENABLE != 0) ? auser : '0;

  logic [RUSER_WIDTH-1:0] ruser_src;
  logic [R_W-1:0] r_in, r_out;

  assign ruser_src = (RUSER_ENABLE != 0) ? bus.ram_rd_resp_user : '0;
  assign r_in = {bus.ram_rd_resp_id, bus.ram_rd_resp_data,
                 bus.ram_rd_resp_last, ruser_src};

`ifdef AXI_RAM_RD_IF_PIPELINE_OUTPUT_EN
  axi_ram_rd_skid #(.WIDTH(R_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (r_in),
    .in_valid (bus.ram_rd_resp_valid),
    .in_ready (bus.ram_rd_resp_ready),
    .out_data (r_out),
    .out_valid(bus.s_axi_rvalid),
    .out_ready(bus.s_axi_rready)
  );
`else
  assign r_out                 = r_in;
  assign bus.s_axi_rvalid      = bus.ram_rd_resp_valid;
  assign bus.ram_rd_resp_ready = bus.s_axi_rready;
`endif

  assign {bus.s_axi_rid, bus.s_axi_rdata,
          bus.s_axi_rlast, bus.s_axi_ruser} = r_out;
  assign bus.s_axi_rresp = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_rd_if.sv
// Directed bench for axi_ram_rd_if with command and response scoreboards.
// Works with or without AXI_RAM_RD_IF_PIPELINE_OUTPUT_EN.
module tb_axi_ram_rd_if;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_rd_if_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8),
    .ARUSER_WIDTH(1), .RUSER_WIDTH(1)
  ) bus ();

  axi_ram_rd_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8),
    .ARUSER_ENABLE(0), .ARUSER_WIDTH(1),
    .RUSER_ENABLE(0), .RUSER_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        last;
    logic [7:0]  id;
  } cmd_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int lat = 0;
  int exp_beats = 0;
  int cmd_beats = 0;
  int r_beats = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Command scoreboard: front entry must be presented whenever cmd_en.
  always @(negedge clk) begin
    if (!rst && bus.ram_rd_cmd_en) begin
      check("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
      if (cmd_q.size() != 0) begin
        check("cmd_addr", 64'(bus.ram_rd_cmd_addr), 64'(cmd_q[0].addr));
        check("cmd_last", 64'(bus.ram_rd_cmd_last), 64'(cmd_q[0].last));
        check("cmd_id", 64'(bus.ram_rd_cmd_id), 64'(cmd_q[0].id));
        check("cmd_auser", 64'(bus.ram_rd_cmd_auser), 64'd0);
        if (bus.ram_rd_cmd_ready) begin
          void'(cmd_q.pop_front());
          cmd_beats++;
        end
      end
    end
  end

  // Response scoreboard: R payload checked every valid cycle, popped on accept.
  always @(negedge clk) begin
    if (!rst && bus.s_axi_rvalid) begin
      check("r_expected", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        check("r_id", 64'(bus.s_axi_rid), 64'(rsp_q[0].id));
        check("r_data", 64'(bus.s_axi_rdata), 64'(rsp_q[0].data));
        check("r_last", 64'(bus.s_axi_rlast), 64'(rsp_q[0].last));
        check("r_resp", 64'(bus.s_axi_rresp), 64'd0);
        check("r_user", 64'(bus.s_axi_ruser), 64'd0);
        if (bus.s_axi_rready) begin
          void'(rsp_q.pop_front());
          r_beats++;
        end
      end
    end
  end

  task automatic start_ar(input logic [7:0] id, input logic [15:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    logic [15:0] a;
    int stride;
    int k;
    a = addr;
    stride = (size > 3'd2) ? 4 : (1 << size);
    for (int i = 0; i <= int'(len); i++) begin
      cmd_q.push_back('{a, (i == int'(len)), id});
      if (burst != 2'b00) a = a + 16'(stride);
    end
    exp_beats += int'(len) + 1;
    bus.s_axi_arid = id;
    bus.s_axi_araddr = addr;
    bus.s_axi_arlen = len;
    bus.s_axi_arsize = size;
    bus.s_axi_arburst = burst;
    bus.s_axi_arprot = 3'd5;
    bus.s_axi_aruser = 1'b1;
    bus.s_axi_arvalid = 1'b1;
    k = 0;
    while (!bus.s_axi_arready && k < 50) begin
      tick();
      k++;
    end
    check("ar_accept", 64'(bus.s_axi_arready), 64'd1);
    tick();
    bus.s_axi_arvalid = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_arready();
    int k;
    k = 0;
    while (!bus.s_axi_arready && k < 200) begin
      tick();
      k++;
    end
    check("arready_return", 64'(bus.s_axi_arready), 64'd1);
    lat = cyc - t0 + 1;
  endtask

  task automatic send_rsp(input logic [7:0] id, input logic [31:0] data,
                          input logic last);
    logic hs;
    int k;
    rsp_q.push_back('{id, data, last});
    bus.ram_rd_resp_id = id;
    bus.ram_rd_resp_data = data;
    bus.ram_rd_resp_last = last;
    bus.ram_rd_resp_valid = 1'b1;
    hs = 1'b0;
    k = 0;
    while (!hs && k < 50) begin
      @(negedge clk);
      hs = bus.ram_rd_resp_ready;
      tick();
      k++;
    end
    check("resp_accept", 64'(hs), 64'd1);
    bus.ram_rd_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic hs;
    bus.s_axi_arid = '0;
    bus.s_axi_araddr = '0;
    bus.s_axi_arlen = '0;
    bus.s_axi_arsize = '0;
    bus.s_axi_arburst = '0;
    bus.s_axi_arlock = 1'b0;
    bus.s_axi_arcache = 4'h3;
    bus.s_axi_arprot = '0;
    bus.s_axi_arqos = '0;
    bus.s_axi_arregion = '0;
    bus.s_axi_aruser = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b1;
    bus.ram_rd_cmd_ready = 1'b1;
    bus.ram_rd_resp_id = '0;
    bus.ram_rd_resp_data = '0;
    bus.ram_rd_resp_last = 1'b0;
    bus.ram_rd_resp_user = 1'b1;
    bus.ram_rd_resp_valid = 1'b0;

    repeat (3) tick();
    check("rst_arready", 64'(bus.s_axi_arready), 64'd0);
    check("rst_cmd_en", 64'(bus.ram_rd_cmd_en), 64'd0);
    check("rst_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
    rst = 1'b0;
    tick();
    check("arready_after_rst", 64'(bus.s_axi_arready), 64'd1);

    // INCR burst, 4 beats, full-rate command ready
    start_ar(8'h11, 16'h0100, 8'd3, 3'd2, 2'b01);
    wait_arready();
    check("incr_latency", 64'(lat), 64'd5);
    check("incr_drained", 64'(cmd_q.size()), 64'd0);

    // FIXED burst stays on one address
    start_ar(8'h22, 16'h0040, 8'd2, 3'd2, 2'b00);
    wait_arready();
    check("fixed_latency", 64'(lat), 64'd4);
    check("fixed_drained", 64'(cmd_q.size()), 64'd0);

    // arsize larger than the bus is clamped to the word size
    start_ar(8'h33, 16'h0200, 8'd2, 3'd3, 2'b01);
    wait_arready();
    check("clamp_drained", 64'(cmd_q.size()), 64'd0);

    // Narrow byte stride, WRAP treated as INCR, address rollover
    start_ar(8'h34, 16'h0301, 8'd2, 3'd0, 2'b01);
    wait_arready();
    start_ar(8'h35, 16'h0400, 8'd1, 3'd1, 2'b10);
    wait_arready();
    start_ar(8'h36, 16'hFFF8, 8'd3, 3'd2, 2'b01);
    wait_arready();
    check("misc_drained", 64'(cmd_q.size()), 64'd0);

    // cmd_ready stalls mid-burst
    start_ar(8'h44, 16'h0500, 8'd3, 3'd2, 2'b01);
    tick();
    bus.ram_rd_cmd_ready = 1'b0;
    tick();
    tick();
    bus.ram_rd_cmd_ready = 1'b1;
    wait_arready();
    check("stall_latency", 64'(lat), 64'd7);
    check("stall_drained", 64'(cmd_q.size()), 64'd0);

    // R channel held by rready low for 3 cycles
    bus.s_axi_rready = 1'b0;
    tick();
    rsp_q.push_back('{8'h5A, 32'hDEADBEEF, 1'b1});
    bus.ram_rd_resp_id = 8'h5A;
    bus.ram_rd_resp_data = 32'hDEADBEEF;
    bus.ram_rd_resp_last = 1'b1;
    bus.ram_rd_resp_valid = 1'b1;
    #1;
`ifdef AXI_RAM_RD_IF_PIPELINE_OUTPUT_EN
    check("r_first_cycle", 64'(bus.s_axi_rvalid), 64'd0);
`else
    check("r_first_cycle", 64'(bus.s_axi_rvalid), 64'd1);
`endif
    for (int i = 0; i < 10; i++) begin
      bus.s_axi_rready = (i >= 3);
      @(negedge clk);
      hs = bus.ram_rd_resp_valid && bus.ram_rd_resp_ready;
      tick();
      if (hs) bus.ram_rd_resp_valid = 1'b0;
      if (i == 0) check("r_second_cycle", 64'(bus.s_axi_rvalid), 64'd1);
    end
    check("r_stall_drained", 64'(rsp_q.size()), 64'd0);

    // Response stream overlapping a command burst
    fork
      begin
        start_ar(8'h55, 16'h0600, 8'd3, 3'd2, 2'b01);
        wait_arready();
      end
      begin
        send_rsp(8'h01, 32'h1111_0000, 1'b0);
        send_rsp(8'h01, 32'h2222_0001, 1'b0);
        send_rsp(8'h01, 32'h3333_0002, 1'b0);
        send_rsp(8'h01, 32'h4444_0003, 1'b1);
      end
    join
    repeat (3) tick();
    check("stream_r_drained", 64'(rsp_q.size()), 64'd0);
    check("stream_cmd_drained", 64'(cmd_q.size()), 64'd0);

    // Reset in the middle of an 8-beat burst
    start_ar(8'h66, 16'h0800, 8'd7, 3'd2, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_cmd_en", 64'(bus.ram_rd_cmd_en), 64'd0);
    check("midrst_arready", 64'(bus.s_axi_arready), 64'd0);
    exp_beats -= cmd_q.size();
    cmd_q.delete();
    rst = 1'b0;
    tick();
    check("midrst_arready_back", 64'(bus.s_axi_arready), 64'd1);
    start_ar(8'h77, 16'h0900, 8'd2, 3'd2, 2'b01);
    wait_arready();
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_drained", 64'(cmd_q.size()), 64'd0);

    tick();
    check("total_cmd_beats", 64'(cmd_beats), 64'(exp_beats));
    check("total_r_beats", 64'(r_beats), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ram_rd_if.md
Name: axi_ram_rd_if

Overview:
AXI4 slave read-side front end for the AXI RAM. It accepts an AR burst and expands it into one RAM read command per beat, with address stepping. It forwards RAM read responses onto the R channel. It pairs with the RAM write interface and sits between the AXI slave port and the RAM core/arbiter.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, bytes per word; must be a power of two
ID_WIDTH, 8, AXI ID width
ARUSER_ENABLE, 0, propagate aruser to RAM command
ARUSER_WIDTH, 1, aruser width
RUSER_ENABLE, 0, propagate RAM response user to ruser
RUSER_WIDTH, 1, ruser width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion/aruser  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/ARUSER_WIDTH  AR payload
s_axi_arvalid  in  1 ; s_axi_arready  out  1
s_axi_rid  out  ID_WIDTH ; s_axi_rdata  out  DATA_WIDTH ; s_axi_rresp  out  2 ; s_axi_rlast  out  1 ; s_axi_ruser  out  RUSER_WIDTH
s_axi_rvalid  out  1 ; s_axi_rready  in  1
ram_rd_cmd_id/addr/lock/cache/prot/qos/region/auser  out  ID_WIDTH/ADDR_WIDTH/1/4/3/4/4/ARUSER_WIDTH  per-beat command fields
ram_rd_cmd_en  out  1  command valid ; ram_rd_cmd_last  out  1  final beat of burst ; ram_rd_cmd_ready  in  1
ram_rd_resp_id  in  ID_WIDTH ; ram_rd_resp_data  in  DATA_WIDTH ; ram_rd_resp_last  in  1 ; ram_rd_resp_user  in  RUSER_WIDTH
ram_rd_resp_valid  in  1 ; ram_rd_resp_ready  out  1

Behaviour:
- Reset (synchronous): state IDLE; arready=0, cmd_en=0, rvalid=0. Command payload registers are not reset. arready rises on the first cycle after rst deasserts.
- State IDLE: arready_next=1. On arvalid&&arready:
  - latch id, addr, lock, cache, prot, qos, region, aruser; count=arlen; burst=arburst.
  - size = min(arsize, clog2(STRB_WIDTH)).
  - cmd_last = (arlen==0); cmd_en_next=1; arready_next=0; go to BURST.
- State BURST: on cmd_en&&cmd_ready:
  - if burst!=FIXED, addr += 1<<size. WRAP is treated as INCR. Address wraps modulo 2^ADDR_WIDTH.
  - count -= 1; cmd_last_next = (count_next==0).
  - if count was 0: cmd_en_next=0, arready_next=1, go to IDLE.
  - Without cmd_ready, all command outputs hold stable.
- Timing: first command is valid the cycle after the AR handshake. Beats issue at 1 per cycle under continuous ready. A burst of arlen+1 beats occupies arlen+2 cycles from the AR handshake to arready reasserting.
- ram_rd_cmd_auser is 0 when ARUSER_ENABLE=0.
- R channel: rresp always 2'b00 (OKAY). rid/rdata/rlast come from the RAM response. ruser is 0 when RUSER_ENABLE=0. Response ordering and count are the RAM's responsibility. The response path is independent of the command FSM, so responses for burst N may overlap command issue for burst N+1.
- Reset mid-burst: remaining beats are dropped; cmd_en is 0 the next cycle.

Optional Feature:
AXI_RAM_RD_IF_PIPELINE_OUTPUT_EN
- Defined: the R channel is driven from a registered 2-entry skid buffer. All R outputs are registered, adding +1 cycle latency. ram_rd_resp_ready = !full (registered). Full throughput is sustained under continuous rready. The buffer is cleared by rst, so rvalid=0 after reset.
- Undefined: combinational pass-through, with s_axi_rvalid=ram_rd_resp_valid, ram_rd_resp_ready=s_axi_rready, and zero latency.

Decomposition:
- Shared package axi_pkg:
  - burst constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10
  - RESP_OKAY=2'b00
  - size-clamp function
- Sub-module axi_ram_rd_skid, the 2-entry skid buffer, instantiated only under the macro.

Test Plan:
- INCR, araddr=0x0100, arlen=3, arsize=2, cmd_ready=1 -> cmd addrs 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles; last on the 4th only; arready high 5 cycles after the handshake.
- FIXED, araddr=0x0040, arlen=2 -> 3 commands all at 0x040; last on the 3rd.
- arsize=3 with DATA_WIDTH=32 -> size clamped to 2; stride 4.
- cmd_ready toggled 1,0,0,1 mid-burst -> outputs held while stalled; no beat lost or duplicated; final count correct.
- RAM responses with id=0x5A, data=0xDEADBEEF, last=1, rready low for 3 cycles -> R outputs stable while stalled; rresp=00. With the macro, rvalid appears 1 cycle later.
- rst asserted in BURST after beat 1 of arlen=7 -> cmd_en=0 next cycle; arready=1 the cycle after rst drops; a new AR burst completes normally.
